// File: rtl/demux_scan_ctrl.sv
//==============================================================================
// Module      : demux_scan_ctrl
// Description : Control stage feeding a 2**SEL_W-way demultiplexer.
//               Single-shot mode drives one data bit onto one addressed
//               channel for a programmed number of cycles, accepted through
//               a valid/ready handshake. Auto-scan mode sweeps all channels
//               in order, holding each one for a programmable dwell time.
//               sel, dout, done and scan_wrap come straight from flops, so
//               the demux never sees glitches.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clk        in   system clock, rising edge active
//   rst        in   asynchronous active-high reset
//   req_valid  in   single-shot request valid
//   req_ready  out  request can be accepted (combinational)
//   req_sel    in   [SEL_W]   target channel of the request
//   req_data   in   data bit to drive on the target channel
//   req_hold   in   [DWELL_W] drive length in cycles (0 behaves as 1)
//   scan_en    in   enable auto-scan
//   scan_dwell in   [DWELL_W] cycles per channel when scanning (0 behaves as 1)
//   sel        out  [SEL_W]   registered channel select
//   dout       out  registered data to the demux input
//   busy       out  controller is not idle
//   done       out  one-cycle pulse when a single-shot completes
//   scan_wrap  out  one-cycle pulse on the first cycle of channel 0 after
//                   the last channel while scanning
//==============================================================================
`default_nettype none

module demux_scan_ctrl #(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEL_W-1:0]   req_sel,
    input  logic               req_data,
    input  logic [DWELL_W-1:0] req_hold,
    input  logic               scan_en,
    input  logic [DWELL_W-1:0] scan_dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               dout,
    output logic               busy,
    output logic               done,
    output logic               scan_wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0]   c_sel_one  = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]   c_sel_last = {SEL_W{1'b1}};
    localparam logic [DWELL_W-1:0] c_cnt_one  = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic               dout_q,  dout_d;
    logic               done_q,  done_d;
    logic               wrap_q,  wrap_d;
    logic [DWELL_W-1:0] cnt_q,   cnt_d;

    // Counter reload values: the counter holds "cycles remaining minus one",
    // so a programmed length of 0 collapses to the same reload as 1.
    logic [DWELL_W-1:0] w_hold_init;
    logic [DWELL_W-1:0] w_dwell_init;

    assign w_hold_init  = (req_hold   == '0) ? '0 : (req_hold   - c_cnt_one);
    assign w_dwell_init = (scan_dwell == '0) ? '0 : (scan_dwell - c_cnt_one);

    // Ready is forced low during reset and whenever scan is requested, so a
    // request can never collide with a scan start.
    assign req_ready = (state_q == ST_IDLE) & ~scan_en & ~rst;
    assign busy      = (state_q != ST_IDLE);
    assign sel       = sel_q;
    assign dout      = dout_q;
    assign done      = done_q;
    assign scan_wrap = wrap_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dout_d = 1'b0;
                if (scan_en) begin
                    state_d = ST_SCAN;
                    sel_d   = '0;
                    dout_d  = 1'b1;
                    cnt_d   = w_dwell_init;
                end else if (req_valid && req_ready) begin
                    state_d = ST_HOLD;
                    sel_d   = req_sel;
                    dout_d  = req_data;
                    cnt_d   = w_hold_init;
                end
            end

            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_one;
                end else begin
                    state_d = ST_IDLE;
                    dout_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            ST_SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_one;
                end else if (scan_en) begin
                    // Dwell is sampled only here, at the start of a channel.
                    sel_d  = sel_q + c_sel_one;
                    dout_d = 1'b1;
                    cnt_d  = w_dwell_init;
                    wrap_d = (sel_q == c_sel_last);
                end else begin
                    // Scan stops only once the current channel has finished.
                    state_d = ST_IDLE;
                    dout_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dout_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_demux_scan_ctrl.sv
//==============================================================================
// Module      : tb_demux_scan_ctrl
// Description : Scoreboard bench for demux_scan_ctrl. The stimulus process
//               queues the transactions it expects (single-shot completions,
//               scan wraps, scan stops); a monitor reconstructs the same
//               transactions from the DUT outputs and compares them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_demux_scan_ctrl;

    localparam int SEL_W   = 4;
    localparam int DWELL_W = 8;

    localparam int K_DONE = 0;
    localparam int K_WRAP = 1;
    localparam int K_STOP = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [SEL_W-1:0]   req_sel;
    logic               req_data;
    logic [DWELL_W-1:0] req_hold;
    logic               scan_en;
    logic [DWELL_W-1:0] scan_dwell;
    logic [SEL_W-1:0]   sel;
    logic               dout;
    logic               busy;
    logic               done;
    logic               scan_wrap;

    always #5 clk = ~clk;

    demux_scan_ctrl #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_data   (req_data),
        .req_hold   (req_hold),
        .scan_en    (scan_en),
        .scan_dwell (scan_dwell),
        .sel        (sel),
        .dout       (dout),
        .busy       (busy),
        .done       (done),
        .scan_wrap  (scan_wrap)
    );

    typedef struct {
        int kind;
        int sel;
        int d;
        int len;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic void push(input int k, input int s, input int d, input int l);
        exp_t e;
        e.kind = k;
        e.sel  = s;
        e.d    = d;
        e.len  = l;
        sb.push_back(e);
    endfunction

    //--------------------------------------------------------------------------
    // Monitor: rebuilds transactions from outputs sampled on the falling edge.
    //--------------------------------------------------------------------------
    initial begin : monitor
        int         run_len   = 0;
        int         wrap_cnt  = 0;
        logic       prev_busy = 1'b0;
        int         prev_sel  = 0;
        int         prev_dout = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
                run_len   = 0;
                wrap_cnt  = 0;
            end else begin
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_kind", K_DONE, e.kind);
                        chk("done_sel", prev_sel, e.sel);
                        chk("done_data", prev_dout, e.d);
                        chk("done_len", run_len, e.len);
                        chk("done_dout_low", int'(dout), 0);
                    end
                end
                if (scan_wrap) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_wrap", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("wrap_kind", K_WRAP, e.kind);
                        chk("wrap_sel", int'(sel), e.sel);
                        chk("wrap_dout", int'(dout), e.d);
                        chk("wrap_period", wrap_cnt, e.len);
                    end
                end
                if (prev_busy && !busy && !done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_stop", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("stop_kind", K_STOP, e.kind);
                        chk("stop_sel", int'(sel), e.sel);
                        chk("stop_last_sel", prev_sel, e.sel);
                        chk("stop_dwell", run_len, e.len);
                        chk("stop_dout", int'(dout), e.d);
                    end
                end
                if (busy) begin
                    run_len  = (prev_busy && (int'(sel) == prev_sel)) ? run_len + 1 : 1;
                    wrap_cnt = (prev_busy && !scan_wrap) ? wrap_cnt + 1 : 1;
                end
                prev_busy = busy;
                prev_sel  = int'(sel);
                prev_dout = int'(dout);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers
    //--------------------------------------------------------------------------
    task automatic wait_ready(input string tag, input int bound);
        int i = 0;
        while (!req_ready && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk({"wait_ready_", tag}, int'(req_ready), 1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int i = 0;
        while (busy && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk({"wait_idle_", tag}, int'(busy), 0);
    endtask

    task automatic do_req(input string tag, input int s, input int d, input int h,
                          input int exp_len);
        req_sel   = SEL_W'(s);
        req_data  = d[0];
        req_hold  = DWELL_W'(h);
        req_valid = 1'b1;
        push(K_DONE, s, d, exp_len);
        #1;
        wait_ready(tag, 20);
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle(tag, h + 10);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    //--------------------------------------------------------------------------
    // Directed stimulus
    //--------------------------------------------------------------------------
    initial begin : stim
        bit found;
        bit ok;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_sel    = '0;
        req_data   = 1'b0;
        req_hold   = '0;
        scan_en    = 1'b0;
        scan_dwell = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_sel", int'(sel), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wrap", int'(scan_wrap), 0);
        chk("rst_ready", int'(req_ready), 0);

        // Request waiting across reset release, then a second request held
        // on valid while the first one is still running.
        req_valid = 1'b1;
        req_sel   = 4'd5;
        req_data  = 1'b1;
        req_hold  = 8'd3;
        push(K_DONE, 5, 1, 3);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", int'(req_ready), 1);
        @(negedge clk);
        chk("t1_busy", int'(busy), 1);
        chk("t1_ready_in_hold", int'(req_ready), 0);
        chk("t1_sel", int'(sel), 5);
        req_sel  = 4'd12;
        req_data = 1'b0;
        req_hold = 8'd2;
        push(K_DONE, 12, 0, 2);
        @(negedge clk);
        chk("t1_ready_in_hold2", int'(req_ready), 0);
        wait_ready("t1b", 10);
        chk("t1_done_with_ready", int'(done), 1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle("t1b", 10);
        @(negedge clk);

        // Zero hold behaves as one cycle; maximum hold gives 255 cycles.
        do_req("hold0", 15, 1, 0, 1);
        do_req("hold255", 3, 1, 255, 255);

        // Auto-scan, dwell 2, with a request parked on valid the whole time.
        scan_dwell = 8'd2;
        scan_en    = 1'b1;
        req_valid  = 1'b1;
        req_sel    = 4'd9;
        req_data   = 1'b0;
        req_hold   = 8'd4;
        push(K_WRAP, 0, 1, 32);
        push(K_WRAP, 0, 1, 32);
        #1;
        chk("scan_blocks_ready", int'(req_ready), 0);
        repeat (70) @(negedge clk);
        chk("scan_busy", int'(busy), 1);
        chk("scan_ready_low", int'(req_ready), 0);
        chk("scan_dout", int'(dout), 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (sel == 4'd7) found = 1'b1;
        end
        chk("wait_sel7", int'(found), 1);
        scan_en = 1'b0;
        push(K_STOP, 7, 0, 2);
        push(K_DONE, 9, 0, 4);
        @(negedge clk);
        chk("stop_dwell_busy", int'(busy), 1);
        chk("stop_dwell_ready", int'(req_ready), 0);
        chk("stop_dwell_sel", int'(sel), 7);
        wait_ready("t4", 5);
        chk("idle_sel_kept", int'(sel), 7);
        chk("idle_dout", int'(dout), 0);
        chk("idle_busy", int'(busy), 0);
        @(negedge clk);
        // Fields changed after acceptance must not disturb the operation.
        req_valid = 1'b0;
        req_sel   = 4'd3;
        req_data  = 1'b1;
        req_hold  = 8'd1;
        wait_idle("t4", 10);
        @(negedge clk);

        // Auto-scan with dwell 0: one cycle per channel.
        scan_dwell = 8'd0;
        scan_en    = 1'b1;
        push(K_WRAP, 0, 1, 16);
        push(K_STOP, 3, 0, 1);
        repeat (20) @(negedge clk);
        chk("d0_sel", int'(sel), 3);
        scan_en = 1'b0;
        wait_idle("t5", 5);
        @(negedge clk);

        // Asynchronous reset in the middle of a long hold.
        req_sel   = 4'd6;
        req_data  = 1'b1;
        req_hold  = 8'd10;
        req_valid = 1'b1;
        #1;
        wait_ready("t6", 5);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_busy_before", int'(busy), 1);
        chk("t6_sel_before", int'(sel), 6);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_sel", int'(sel), 0);
        chk("t6_async_dout", int'(dout), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_ready", int'(req_ready), 0);
        @(negedge clk);
        chk("t6_no_done", int'(done), 0);
        rst = 1'b0;
        ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (busy || done || dout) ok = 1'b0;
        end
        chk("t6_no_resume", int'(ok), 1);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux_scan_ctrl.md
Name: demux_scan_ctrl

Overview:
- Control stage directly upstream of the 4-to-16 demultiplexer. Drives its `sel[3:0]` and `in` inputs.
- Two operating modes:
  - Single-shot: writes one data bit to one addressed channel for a programmed number of cycles, via a valid/ready request handshake.
  - Auto-scan: sweeps channels 0..15 continuously, asserting the data bit on each channel for a programmable dwell time.
- All outputs are registered, so the demux sees glitch-free select and data.

Parameters:
- SEL_W, 4, width of the channel select. The number of channels is 2**SEL_W.
- DWELL_W, 8, width of the hold and dwell cycle counts.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  single-shot request is valid
- req_ready  output  1  block can accept a request
- req_sel  input  SEL_W  target channel for the request
- req_data  input  1  data bit to drive on the target channel
- req_hold  input  DWELL_W  number of cycles to drive; 0 is treated as 1
- scan_en  input  1  enable auto-scan mode
- scan_dwell  input  DWELL_W  cycles per channel in scan mode; 0 is treated as 1
- sel  output  SEL_W  channel select to demux, registered
- dout  output  1  data to demux `in`, registered
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse when a single-shot completes
- scan_wrap  output  1  one-cycle pulse when sel wraps from 15 to 0 in scan mode

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - state=IDLE, sel=0, dout=0, done=0, scan_wrap=0, counter=0.
  - busy=0 and req_ready=0 while rst is high.
- req_ready = (state==IDLE) & ~scan_en & ~rst. It is combinational from state and inputs.
- busy = (state!=IDLE).
- States: IDLE, HOLD, SCAN.
- IDLE:
  - dout=0; sel retains its last value.
  - If scan_en=1: next state is SCAN. On that same edge load sel=0, dout=1, counter=max(scan_dwell,1)-1.
  - Else if req_valid & req_ready: next state is HOLD. On that same edge load sel=req_sel, dout=req_data, counter=max(req_hold,1)-1.
  - scan_en has priority over a request. No conflict is possible, because req_ready=0 whenever scan_en=1.
- HOLD:
  - While counter!=0: decrement counter.
  - When counter==0: next state IDLE, dout=0, done=1 for one cycle (the first IDLE cycle).
  - dout is therefore high or low (per req_data) for exactly max(req_hold,1) cycles.
  - scan_en and req_valid are ignored in HOLD. A requester must keep req_valid asserted until it sees req_ready.
- SCAN:
  - While counter!=0: decrement counter.
  - When counter==0 and scan_en=1: sel=sel+1 (mod 2**SEL_W), dout=1, counter reloads with max(scan_dwell,1)-1. scan_dwell is sampled only at channel start.
  - If that increment wraps 15 to 0: scan_wrap=1 for the cycle in which sel=0.
  - When counter==0 and scan_en=0: next state IDLE, dout=0, sel retained, no scan_wrap. The current channel always completes its full dwell before scan stops.
- done and scan_wrap are deasserted in every cycle not specified above.
- Counter arithmetic: unsigned DWELL_W bits with no overflow. A maximum hold of 255 gives 255 cycles.
- Reset mid-HOLD or mid-SCAN: outputs return to reset values immediately, done is not asserted, and the pending request is lost.
- Changes on req_sel, req_data or req_hold after acceptance have no effect on the operation in progress.

Test Plan:
- Reset, then req_valid=1, req_sel=5, req_data=1, req_hold=3 → accepted on the first edge after reset release; sel=5 and dout=1 for exactly 3 cycles; then dout=0, done=1 for 1 cycle, req_ready=1 again.
- Request with req_hold=0, req_sel=15 → dout=1 on sel=15 for exactly 1 cycle, then done pulse.
- scan_en=1, scan_dwell=2 → sel steps 0,0,1,1,...,15,15,0 with dout=1 throughout; scan_wrap=1 only in the first cycle of sel=0 after 15; wrap period is 32 cycles.
- During scan at sel=7 (first dwell cycle), drop scan_en → sel=7 completes its dwell of 2 cycles, then IDLE with dout=0, sel=7, busy=0.
- Assert req_valid during HOLD and while scan_en=1 → req_ready=0 and no acceptance; the request is accepted on the first IDLE cycle with scan_en=0.
- Assert rst asynchronously mid-HOLD (hold=10, cycle 4) → sel=0, dout=0 immediately with no clock edge; no done pulse; request not resumed after release.
